// File: rtl/rijndael_round_tail_if.sv
// Handshake bundle for the round-tail stage: upstream beat (state, key, last)
// and downstream beat (next state, last), each with valid/ready.
interface rijndael_round_tail_if #(
  parameter int NB = 4
);
  localparam int STATESIZE = 32 * NB;

  logic                 valid_i;
  logic                 ready_o;
  logic [STATESIZE-1:0] state_i;
  logic [STATESIZE-1:0] roundkey_i;
  logic                 last_i;
  logic                 valid_o;
  logic                 ready_i;
  logic [STATESIZE-1:0] state_o;
  logic                 last_o;

  // The stage itself.
  modport slave (
    input  valid_i, state_i, roundkey_i, last_i, ready_i,
    output ready_o, valid_o, state_o, last_o
  );

  // Whoever drives the stage and consumes its results.
  modport master (
    output valid_i, state_i, roundkey_i, last_i, ready_i,
    input  ready_o, valid_o, state_o, last_o
  );
endinterface

// File: rtl/rijndael_round_tail.sv
// Rijndael round tail: ShiftRows -> MixColumns (skipped on the final round) ->
// AddRoundKey, registered behind a valid/ready stage with a one-entry skid buffer.
module rijndael_round_tail #(
  parameter int NB = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  rijndael_round_tail_if.slave rt
);
  localparam int STATESIZE = 32 * NB;
  localparam int C1 = 1;
  localparam int C2 = (NB == 8) ? 3 : 2;
  localparam int C3 = (NB == 8) ? 4 : 3;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column bytes: [7:0] is row 0 ... [31:24] is row 3.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[7:0];
    a1 = col[15:8];
    a2 = col[23:16];
    a3 = col[31:24];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b3, b2, b1, b0};
  endfunction

  logic [STATESIZE-1:0] sr_state;
  logic [STATESIZE-1:0] mc_state;
  logic [STATESIZE-1:0] round_state;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_col
      for (genvar gr = 0; gr < 4; gr++) begin : g_row
        localparam int SH  = (gr == 0) ? 0 : (gr == 1) ? C1 : (gr == 2) ? C2 : C3;
        localparam int SRC = (((gi + SH) % NB) * 4) + gr;
        assign sr_state[8*(4*gi+gr) +: 8] = rt.state_i[8*SRC +: 8];
      end
      assign mc_state[32*gi +: 32] = mix_column(sr_state[32*gi +: 32]);
    end
  endgenerate

  assign round_state = (rt.last_i ? sr_state : mc_state) ^ rt.roundkey_i;

  // O is the visible output register, S the skid entry that absorbs the one
  // beat accepted while O is stalled.
  logic                 o_valid_reg, o_valid_next;
  logic [STATESIZE-1:0] o_state_reg, o_state_next;
  logic                 o_last_reg,  o_last_next;
  logic                 s_valid_reg, s_valid_next;
  logic [STATESIZE-1:0] s_state_reg, s_state_next;
  logic                 s_last_reg,  s_last_next;
  logic                 ready_reg,   ready_next;
  logic                 accept;
  logic                 drain;

  assign accept = rt.valid_i && ready_reg;
  assign drain  = o_valid_reg && rt.ready_i;

  always_comb begin
    o_valid_next = o_valid_reg;
    o_state_next = o_state_reg;
    o_last_next  = o_last_reg;
    s_valid_next = s_valid_reg;
    s_state_next = s_state_reg;
    s_last_next  = s_last_reg;
    if (drain) begin
      if (s_valid_reg) begin
        o_state_next = s_state_reg;
        o_last_next  = s_last_reg;
        s_valid_next = 1'b0;
      end else if (accept) begin
        o_state_next = round_state;
        o_last_next  = rt.last_i;
      end else begin
        o_valid_next = 1'b0;
      end
    end else if (accept) begin
      if (!o_valid_reg) begin
        o_valid_next = 1'b1;
        o_state_next = round_state;
        o_last_next  = rt.last_i;
      end else begin
        s_valid_next = 1'b1;
        s_state_next = round_state;
        s_last_next  = rt.last_i;
      end
    end
    ready_next = !s_valid_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      o_valid_reg <= 1'b0;
      o_state_reg <= '0;
      o_last_reg  <= 1'b0;
      s_valid_reg <= 1'b0;
      s_state_reg <= '0;
      s_last_reg  <= 1'b0;
      ready_reg   <= 1'b1;
    end else begin
      o_valid_reg <= o_valid_next;
      o_state_reg <= o_state_next;
      o_last_reg  <= o_last_next;
      s_valid_reg <= s_valid_next;
      s_state_reg <= s_state_next;
      s_last_reg  <= s_last_next;
      ready_reg   <= ready_next;
    end
  end

  assign rt.ready_o = ready_reg;
  assign rt.valid_o = o_valid_reg;
  assign rt.state_o = o_state_reg;
  assign rt.last_o  = o_last_reg;
endmodule

// File: tb/tb_rijndael_round_tail.sv
// Bench for rijndael_round_tail: NB=4 and NB=8 instances, scoreboard against a
// byte-matrix reference of the round transform.
module tb_rijndael_round_tail;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rijndael_round_tail_if #(.NB(4)) if4 ();
  rijndael_round_tail_if #(.NB(8)) if8 ();

  rijndael_round_tail #(.NB(4)) u4 (.clk_i(clk), .rst_i(rst), .rt(if4));
  rijndael_round_tail #(.NB(8)) u8 (.clk_i(clk), .rst_i(rst), .rt(if8));

  typedef struct {
    logic [127:0] st;
    logic         last;
  } beat_t;

  beat_t sb[$];
  int total = 0;
  int bad = 0;
  int n_out = 0;
  int n_acc = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Carry-less multiply then reduce modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p ^= ({7'b0, a} << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p ^= (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [255:0] ref_round(input logic [255:0] st, input logic [255:0] key,
                                             input logic last, input int nb);
    logic [7:0] s[4][8];
    logic [7:0] t[4][8];
    logic [7:0] v;
    int sh[4];
    int base[4];
    logic [255:0] res;
    sh   = '{0, 1, (nb == 8) ? 3 : 2, (nb == 8) ? 4 : 3};
    base = '{2, 3, 1, 1};
    res  = '0;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = st[8*(4*c+r) +: 8];
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        t[r][c] = s[r][(c + sh[r]) % nb];
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) begin
        if (last) v = t[r][c];
        else begin
          v = '0;
          for (int j = 0; j < 4; j++)
            v ^= gmul(8'(base[(j - r + 4) % 4]), t[j][c]);
        end
        res[8*(4*c+r) +: 8] = v ^ key[8*(4*c+r) +: 8];
      end
    return res;
  endfunction

  // Literal written byte 0 first (MSB end) -> bus with byte 0 at [7:0].
  function automatic logic [127:0] bytes16(input logic [127:0] lit);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = lit[127-8*k -: 8];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input logic v, input logic [127:0] s, input logic [127:0] k, input logic l);
    if4.valid_i    = v;
    if4.state_i    = s;
    if4.roundkey_i = k;
    if4.last_i     = l;
  endtask

  // Called just after a falling edge with inputs settled; scores the transfers
  // the next rising edge will perform, then advances one cycle.
  task automatic cycle();
    logic [255:0] tmp;
    beat_t b;
    if (if4.valid_o && if4.ready_i) begin
      n_out++;
      if (sb.size() == 0) check("unexpected_out", 1, 0);
      else begin
        b = sb.pop_front();
        check("out_state", if4.state_o, b.st);
        check("out_last", if4.last_o, b.last);
      end
    end
    if (if4.valid_i && if4.ready_o) begin
      n_acc++;
      tmp    = ref_round({128'b0, if4.state_i}, {128'b0, if4.roundkey_i}, if4.last_i, 4);
      b.st   = tmp[127:0];
      b.last = if4.last_i;
      sb.push_back(b);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [127:0] fips_st, fips_key;
  logic [255:0] st8, exp8;
  int out0;

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    if4.ready_i = 1'b0;
    if8.valid_i = 1'b0;
    if8.state_i = '0;
    if8.roundkey_i = '0;
    if8.last_i = 1'b0;
    if8.ready_i = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", if4.valid_o, 0);
    check("rst_ready", if4.ready_o, 1);
    check("rst_state", if4.state_o, 0);
    check("rst_last", if4.last_o, 0);
    rst = 1'b0;

    // FIPS-197 round 1
    fips_st  = bytes16(128'hd42711aee0bf98f1b8b45de51e415230);
    fips_key = bytes16(128'ha0fafe1788542cb123a339392a6c7605);
    if4.ready_i = 1'b1;
    drive(1'b1, fips_st, fips_key, 1'b0);
    cycle();
    drive(1'b0, '0, '0, 1'b0);
    check("fips_valid", if4.valid_o, 1);
    check("fips_state", if4.state_o, bytes16(128'ha49c7ff2689f352b6b5bea43026a5049));
    check("fips_last", if4.last_o, 0);
    cycle();

    // Final-round bypass
    drive(1'b1, fips_st, '0, 1'b1);
    cycle();
    drive(1'b0, '0, '0, 1'b0);
    check("final_valid", if4.valid_o, 1);
    check("final_state", if4.state_o, bytes16(128'hd4bf5d30e0b452aeb84111f11e2798e5));
    check("final_last", if4.last_o, 1);
    cycle();
    check("final_drained", if4.valid_o, 0);

    // Backpressure
    if4.ready_i = 1'b0;
    n_acc = 0;
    drive(1'b1, rnd128(), rnd128(), 1'($urandom));
    check("bp_ready_b1", if4.ready_o, 1);
    cycle();
    drive(1'b1, rnd128(), rnd128(), 1'($urandom));
    check("bp_ready_b2", if4.ready_o, 1);
    cycle();
    drive(1'b1, rnd128(), rnd128(), 1'($urandom));
    check("bp_ready_low", if4.ready_o, 0);
    cycle();
    check("bp_stall_ready", if4.ready_o, 0);
    check("bp_hold_valid", if4.valid_o, 1);
    check("bp_hold_state", if4.state_o, {128'b0, sb[0].st});
    cycle();
    check("bp_accepted", n_acc, 2);
    check("bp_hold_state2", if4.state_o, {128'b0, sb[0].st});
    if4.ready_i = 1'b1;
    cycle();
    check("bp_ready_back", if4.ready_o, 1);
    check("bp_valid_b2", if4.valid_o, 1);
    cycle();
    drive(1'b0, '0, '0, 1'b0);
    check("bp_valid_b3", if4.valid_o, 1);
    cycle();
    check("bp_all_out", sb.size(), 0);
    check("bp_idle", if4.valid_o, 0);

    // Throughput
    out0 = n_out;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, rnd128(), rnd128(), 1'($urandom));
      check("tp_ready", if4.ready_o, 1);
      if (i > 0) check("tp_valid", if4.valid_o, 1);
      cycle();
    end
    drive(1'b0, '0, '0, 1'b0);
    check("tp_valid_last", if4.valid_o, 1);
    cycle();
    check("tp_count", n_out - out0, 20);
    check("tp_idle", if4.valid_o, 0);

    // NB=8 ShiftRows
    for (int k = 0; k < 32; k++) st8[8*k +: 8] = 8'(k);
    if8.state_i = st8;
    if8.roundkey_i = '0;
    if8.last_i = 1'b1;
    if8.valid_i = 1'b1;
    check("nb8_ready", if8.ready_o, 1);
    @(posedge clk);
    @(negedge clk);
    if8.valid_i = 1'b0;
    exp8 = ref_round(st8, '0, 1'b1, 8);
    check("nb8_valid", if8.valid_o, 1);
    check("nb8_r2c0", if8.state_o[23:16], 8'h0e);
    check("nb8_r3c0", if8.state_o[31:24], 8'h13);
    check("nb8_state", if8.state_o, exp8);
    check("nb8_last", if8.last_o, 1);
    for (int k = 0; k < 32; k++) st8[8*k +: 8] = 8'($urandom);
    if8.state_i = st8;
    if8.roundkey_i = {rnd128(), rnd128()};
    if8.last_i = 1'b0;
    if8.valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if8.valid_i = 1'b0;
    exp8 = ref_round(st8, if8.roundkey_i, 1'b0, 8);
    check("nb8_mix_state", if8.state_o, exp8);

    // Reset with O and S both full
    if4.ready_i = 1'b0;
    drive(1'b1, rnd128(), rnd128(), 1'b1);
    cycle();
    drive(1'b1, rnd128(), rnd128(), 1'b1);
    cycle();
    drive(1'b0, '0, '0, 1'b0);
    check("mr_full_ready", if4.ready_o, 0);
    check("mr_full_valid", if4.valid_o, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("mr_valid", if4.valid_o, 0);
    check("mr_state", if4.state_o, 0);
    check("mr_last", if4.last_o, 0);
    check("mr_ready", if4.ready_o, 1);
    if4.ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("mr_no_stale", if4.valid_o, 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rijndael_round_tail.md
Name: rijndael_round_tail

Overview:
- Registered round-tail stage directly downstream of the SubBytes stage.
- Takes the substituted state and applies ShiftRows, then MixColumns (bypassed on the final round), then AddRoundKey, producing the next round state.
- Valid/ready handshake on both sides with a one-entry skid buffer, so the stage runs at full throughput and ready_o comes straight from a register.
- Sits in the iterative and unrolled cipher datapaths between the SubBytes stage and the next round's SubBytes input.

Parameters:
- NB, 4, state width in 32-bit columns; legal values 4, 6, 8.
- STATESIZE, 32*NB, state width in bits; localparam, not overridable.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  state_i, roundkey_i and last_i are valid.
- ready_o  output  1  stage can accept a beat.
- state_i  input  STATESIZE  SubBytes output; byte k = state_i[8*k+7 -: 8], column c = k/4, row r = k%4.
- roundkey_i  input  STATESIZE  round key, same byte layout as state_i.
- last_i  input  1  final round: skip MixColumns.
- valid_o  output  1  state_o and last_o are valid.
- ready_i  input  1  downstream accepts a beat.
- state_o  output  STATESIZE  next round state.
- last_o  output  1  last_i carried alongside the beat.

Behaviour:
- Reset (rst_i=1 at a clock edge): valid_o=0, last_o=0, state_o=0, skid buffer empty, ready_o=1. Reset overrides a simultaneous handshake; any beat in flight is dropped.
- Input transfer happens when valid_i && ready_o. Output transfer happens when valid_o && ready_i.
- ShiftRows: out[r][c] = in[r][(c + C_r) mod NB].
  - C_0 = 0 for all NB.
  - NB=4 or 6: C_1=1, C_2=2, C_3=3.
  - NB=8: C_1=1, C_2=3, C_3=4.
- MixColumns: per column, GF(2^8) with reduction polynomial 0x11B, matrix rows {02 03 01 01}, {01 02 03 01}, {01 01 02 03}, {03 01 01 02}; xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0).
- If last_i=1, the MixColumns result is replaced by the ShiftRows result.
- AddRoundKey: bitwise XOR with roundkey_i.
- All transforms are combinational in front of the output register. Latency is exactly 1 cycle from input transfer to valid_o=1 when the output register is empty or draining.
- Output register (O) and skid register (S) rules:
  - Accept while O empty, or O draining this cycle (ready_i=1) with S empty: result goes to O.
  - Accept while O full and not draining: result goes to S; ready_o=0 from the next cycle.
  - O drains while S full: S moves to O, S empties, ready_o=1 from the next cycle.
  - O drains with S empty and no accept: valid_o=0 next cycle.
  - Simultaneous accept and drain with S empty: O is overwritten with the new beat; no bubble.
- ready_o = !S_full, registered. It does not depend combinationally on ready_i or valid_i.
- While valid_o=1 && ready_i=0, state_o and last_o are held stable.
- Beats leave in acceptance order; none are lost or duplicated.
- A beat's last_i travels with it to last_o.
- valid_i is ignored while ready_o=0. Upstream holds its data; no requirement on upstream stability beyond the standard valid/ready rule.

Test Plan:
- NB=4, FIPS-197 App. B round 1 (bytes listed byte 0 first):
  - Inputs: state_i = d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30; roundkey_i = a0 fa fe 17 88 54 2c b1 23 a3 39 39 2a 6c 76 05; last_i=0; ready_i=1.
  - Required: one cycle later valid_o=1, state_o = a4 9c 7f f2 68 9f 35 2b 6b 5b ea 43 02 6a 50 49, last_o=0.
- Final-round bypass:
  - Inputs: same state_i, roundkey_i=0, last_i=1.
  - Required: state_o = d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5 (pure ShiftRows), last_o=1.
- Backpressure:
  - Stimulus: 3 back-to-back beats with ready_i=0.
  - Required: beats 1 and 2 accepted; ready_o=0 the cycle after beat 2; beat 3 stalls.
  - Then raise ready_i: outputs appear in order 1, 2, 3 with no gaps after the first; ready_o returns to 1 one cycle after S drains.
- Throughput:
  - Stimulus: 20 random beats, valid_i=1 and ready_i=1 throughout.
  - Required: ready_o stays 1; 20 outputs on 20 consecutive cycles; each matches the reference-model round transform.
- NB=8 ShiftRows:
  - Stimulus: state_i byte k = k, roundkey_i=0, last_i=1.
  - Required: row 2 of column 0 = byte of column 3 (value 0x0e); row 3 of column 0 = byte of column 4 (value 0x13).
- Reset mid-operation:
  - Stimulus: O and S both full, assert rst_i for one cycle.
  - Required: next cycle valid_o=0, state_o=0, ready_o=1; stale beats are never output.
